// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light controller.
// Holds the state encoding, the default timings and the counter-width helper.
package tlc_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    RED    = 2'b10
  } tlc_state_t;

  localparam int DEF_MIN_GREEN   = 4;
  localparam int DEF_YELLOW_TIME = 2;
  localparam int DEF_RED_TIME    = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // The dwell counter only ever holds values up to (largest timing - 1).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = max3(a, b, c);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/traffic_light_controller.sv
// Main-road traffic light: holds green until a side-road car is seen and the
// minimum green time has elapsed, then runs a fixed yellow and red phase.
module traffic_light_controller
  import tlc_pkg::*;
#(
  parameter int MIN_GREEN   = DEF_MIN_GREEN,
  parameter int YELLOW_TIME = DEF_YELLOW_TIME,
  parameter int RED_TIME    = DEF_RED_TIME
) (
  input  logic clk,
  input  logic reset,
  input  logic car_detect,
  output logic green,
  output logic yellow,
  output logic red
);

  localparam int CW = cnt_width(MIN_GREEN, YELLOW_TIME, RED_TIME);
  localparam logic [CW-1:0] G_LAST = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(YELLOW_TIME - 1);
  localparam logic [CW-1:0] R_LAST = CW'(RED_TIME - 1);

  tlc_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          req_q;
  logic          go;
  logic          in_req_state;

  assign go           = req_q | car_detect;
  assign in_req_state = (state_q == GREEN) || (state_q == YELLOW);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= GREEN;
    else        state_q <= state_d;
  end

  // Counter saturates in GREEN, so equality with G_LAST means "minimum met".
  always_comb begin
    state_d = state_q;
    case (state_q)
      GREEN:   if (go && cnt_q == G_LAST) state_d = YELLOW;
      YELLOW:  if (cnt_q == Y_LAST)       state_d = RED;
      RED:     if (cnt_q == R_LAST)       state_d = GREEN;
      default:                            state_d = GREEN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   cnt_q <= '0;
    else if (state_d != state_q)  cnt_q <= '0;
    else if (state_q == GREEN)    cnt_q <= (cnt_q == G_LAST) ? cnt_q : cnt_q + CW'(1);
    else                          cnt_q <= cnt_q + CW'(1);
  end

  // The request is consumed when RED is entered; RED itself ignores cars.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            req_q <= 1'b0;
    else if (state_d == RED || !in_req_state) req_q <= 1'b0;
    else if (car_detect)                   req_q <= 1'b1;
  end

  always_comb begin
    green  = 1'b1;
    yellow = 1'b0;
    red    = 1'b0;
    case (state_q)
      YELLOW:  begin green = 1'b0; yellow = 1'b1; end
      RED:     begin green = 1'b0; red    = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Self-checking bench: directed scenarios plus random car/reset traffic,
// compared every cycle against a phase/elapsed-time reference model.
module tb_traffic_light_controller;

  localparam int MG = 4;
  localparam int YT = 2;
  localparam int RT = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic car_detect = 1'b0;
  logic green, yellow, red;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_light_controller #(
    .MIN_GREEN(MG), .YELLOW_TIME(YT), .RED_TIME(RT)
  ) dut (
    .clk(clk), .reset(reset), .car_detect(car_detect),
    .green(green), .yellow(yellow), .red(red)
  );

  // Reference: phase 0=green 1=yellow 2=red, tm = cycles already spent in phase.
  int ph = 0;
  int tm = 0;
  bit pend = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph = 0; tm = 0; pend = 0;
    end else begin
      case (ph)
        0: begin
          bit go_now;
          go_now = pend || car_detect;
          if (car_detect) pend = 1;
          if (go_now && tm + 1 >= MG) begin ph = 1; tm = 0; end
          else tm++;
        end
        1: begin
          if (car_detect) pend = 1;
          if (tm + 1 == YT) begin ph = 2; tm = 0; pend = 0; end
          else tm++;
        end
        default: begin
          if (tm + 1 == RT) begin ph = 0; tm = 0; end
          else tm++;
        end
      endcase
    end
  end

  function automatic logic [2:0] model_lamps();
    return (ph == 0) ? 3'b100 : (ph == 1) ? 3'b010 : 3'b001;
  endfunction

  task automatic test_reset();
    reset = 1'b0; car_detect = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({green, yellow, red} !== 3'b100) begin
        errors++; $display("FAIL reset_hold got %b exp 100", {green, yellow, red});
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({green, yellow, red} !== 3'b100 || model_lamps() !== 3'b100) begin
        errors++; $display("FAIL reset_idle cyc %0d got %b exp 100", i, {green, yellow, red});
      end
    end
  endtask

  task automatic test_single_pulse();
    logic [2:0] exp;
    car_detect = 1'b0;
    repeat (10) @(negedge clk);
    car_detect = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      car_detect = 1'b0;
      exp = (i < YT) ? 3'b010 : (i < YT + RT) ? 3'b001 : 3'b100;
      checks++;
      if ({green, yellow, red} !== exp || model_lamps() !== exp) begin
        errors++; $display("FAIL single_pulse cyc %0d got %b exp %b", i, {green, yellow, red}, exp);
      end
    end
  endtask

  task automatic test_early_pulse();
    logic [2:0] exp;
    bit found;
    found = 0;
    // Launch one cycle, then stop on the first green cycle after red.
    car_detect = 1'b1;
    @(negedge clk);
    car_detect = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (ph == 0) found = 1;
    end
    checks++;
    if (!found || green !== 1'b1) begin
      errors++; $display("FAIL early_pulse_sync got green=%b found=%0d exp 1", green, found);
    end
    car_detect = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      car_detect = 1'b0;
      exp = (i < MG - 1) ? 3'b100 : (i < MG - 1 + YT) ? 3'b010 :
            (i < MG - 1 + YT + RT) ? 3'b001 : 3'b100;
      checks++;
      if ({green, yellow, red} !== exp) begin
        errors++; $display("FAIL early_pulse cyc %0d got %b exp %b", i, {green, yellow, red}, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    car_detect = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++;
      if (!$onehot({green, yellow, red}) || {green, yellow, red} !== model_lamps()) begin
        errors++; $display("FAIL held_car cyc %0d got %b exp %b", i, {green, yellow, red}, model_lamps());
      end
    end
    car_detect = 1'b0;
    // Drain any request left over from the held input.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({green, yellow, red} !== model_lamps()) begin
        errors++; $display("FAIL held_drain cyc %0d got %b exp %b", i, {green, yellow, red}, model_lamps());
      end
    end
  endtask

  task automatic test_red_pulse();
    bit found;
    int yel;
    found = 0; yel = 0;
    car_detect = 1'b1;
    @(negedge clk);
    car_detect = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (ph == 2) found = 1;
    end
    checks++;
    if (!found || red !== 1'b1) begin
      errors++; $display("FAIL red_pulse_sync got red=%b found=%0d exp 1", red, found);
    end
    car_detect = 1'b1;
    @(negedge clk);
    car_detect = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (yellow === 1'b1) yel++;
    end
    checks++;
    if (yel != 0 || green !== 1'b1) begin
      errors++; $display("FAIL red_pulse_ignored got yellow_cycles=%0d green=%b exp 0 and 1", yel, green);
    end
  endtask

  task automatic test_async_reset();
    bit found;
    int yel;
    found = 0; yel = 0;
    car_detect = 1'b1;
    @(negedge clk);
    car_detect = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (ph == 2) found = 1;
    end
    checks++;
    if (!found || red !== 1'b1) begin
      errors++; $display("FAIL async_sync got red=%b found=%0d exp 1", red, found);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({green, yellow, red} !== 3'b100) begin
      errors++; $display("FAIL async_reset got %b exp 100", {green, yellow, red});
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (yellow === 1'b1) yel++;
    end
    checks++;
    if (yel != 0 || green !== 1'b1) begin
      errors++; $display("FAIL async_after got yellow_cycles=%0d green=%b exp 0 and 1", yel, green);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      checks++;
      if ({green, yellow, red} !== model_lamps()) begin
        errors++; $display("FAIL random cyc %0d got %b exp %b", i, {green, yellow, red}, model_lamps());
      end
      car_detect = ($urandom_range(0, 5) == 0);
      reset      = ($urandom_range(0, 60) != 0);
    end
    reset = 1'b1; car_detect = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_early_pulse();
    test_back_to_back();
    test_red_pulse();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_light_controller.md
TRAFFIC_LIGHT_CONTROLLER -- requirements
Module: traffic_light_controller

Interface
REQ-001 Parameter MIN_GREEN, default 4: minimum GREEN dwell in clock cycles, >=1.
REQ-002 Parameter YELLOW_TIME, default 2: exact YELLOW dwell in clock cycles, >=1.
REQ-003 Parameter RED_TIME, default 3: exact RED dwell in clock cycles, >=1.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 car_detect  input  1  synchronous side-road vehicle request; a one-cycle pulse SHALL be sufficient.
REQ-007 green  output  1  main-road green lamp.
REQ-008 yellow  output  1  main-road yellow lamp.
REQ-009 red  output  1  main-road red lamp.

Function
REQ-010 The FSM SHALL have exactly three states: GREEN, YELLOW, RED; outputs are a Moore decode, exactly one lamp high in every cycle.
REQ-011 A dwell counter SHALL clear on every state entry, increment each cycle in the state, and saturate at MIN_GREEN-1 in GREEN; width = clog2 of the largest parameter, minimum 1 bit.
REQ-012 A request flag req_q SHALL be set on any rising edge in GREEN or YELLOW at which car_detect=1, and held until RED is entered.
REQ-013 Define go = req_q OR car_detect.
REQ-014 GREEN->YELLOW SHALL occur at the edge where go=1 and counter >= MIN_GREEN-1; otherwise GREEN SHALL be held indefinitely (no cars => permanent green).
REQ-015 YELLOW->RED SHALL occur at the edge where counter = YELLOW_TIME-1; car_detect has no effect in YELLOW beyond REQ-012.
REQ-016 RED->GREEN SHALL occur at the edge where counter = RED_TIME-1.
REQ-017 req_q SHALL clear at the YELLOW->RED edge; car_detect sampled during RED SHALL be ignored (vehicle being served).
REQ-018 A request arriving while GREEN has lasted fewer than MIN_GREEN cycles SHALL be remembered and honoured at the first edge where the minimum is met.
REQ-019 Held car_detect=1 SHALL produce continuous cycling G(MIN_GREEN)->Y(YELLOW_TIME)->R(RED_TIME)->G...
REQ-020 Unreachable state encodings SHALL recover to GREEN on the next edge with counter and req_q cleared.

Reset
REQ-021 reset=0 SHALL immediately, without a clock, force state GREEN, counter 0, req_q 0.
REQ-022 Reset values: green=1, yellow=0, red=0.
REQ-023 Reset asserted mid-YELLOW or mid-RED SHALL abort the cycle and discard any pending request.
REQ-024 After reset release, the first GREEN dwell SHALL be counted from the first rising edge with reset=1.

Structure
REQ-025 Shared package tlc_pkg SHALL hold the state type/encoding (GREEN, YELLOW, RED) and the default timing constants.
REQ-026 Single module; no sub-module; state register, counter, request flag and output decode in one block.

Verification (defaults 4/2/3)
REQ-027 Reset low 2 cycles, car_detect=0 -> green=1,yellow=0,red=0 during reset and for 20 cycles after release.
REQ-028 Release reset, 10 cycles, 1-cycle car_detect pulse -> yellow high exactly 2 cycles starting after that edge, then red exactly 3 cycles, then green stays high.
REQ-029 car_detect pulse on 1st green cycle after red/reset -> green lasts exactly 4 cycles total, then yellow 2, red 3.
REQ-030 car_detect held high 30 cycles -> periodic pattern 4G/2Y/3R; exactly one lamp high every cycle.
REQ-031 car_detect pulse only during red -> after red, green held indefinitely (no second cycle).
REQ-032 reset asserted asynchronously mid-red -> green=1 before next clock edge; no yellow until a new car_detect.
